// File: rtl/tqvp_wave_dds.sv
`default_nettype none
// ============================================================================
//  Module      : tqvp_wave_dds
//  Description : Register-mapped direct digital synthesis waveform generator.
//                16-bit phase accumulator feeding a two-stage sample pipeline
//                (waveform shaping, then amplitude scaling / inversion).
//  Revision    : 1.0 - initial release
// ============================================================================
module tqvp_wave_dds (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    localparam logic [3:0] c_ADDR_CTRL     = 4'h0;
    localparam logic [3:0] c_ADDR_INC_LO   = 4'h1;
    localparam logic [3:0] c_ADDR_INC_HI   = 4'h2;
    localparam logic [3:0] c_ADDR_AMPL     = 4'h3;
    localparam logic [3:0] c_ADDR_DUTY     = 4'h4;
    localparam logic [3:0] c_ADDR_PHASE_HI = 4'h5;
    localparam logic [3:0] c_ADDR_WRAP_CNT = 4'h6;

    localparam logic [1:0] c_WAVE_SQUARE   = 2'd0;
    localparam logic [1:0] c_WAVE_SAW      = 2'd1;
    localparam logic [1:0] c_WAVE_TRIANGLE = 2'd2;
    localparam logic [1:0] c_WAVE_NOISE    = 2'd3;

    // Register state
    logic [15:0] r_phase;
    logic [15:0] r_inc;
    logic [7:0]  r_shadow;
    logic [4:0]  r_ctrl;       // [0] enable, [2:1] wave, [3] sync_en, [4] invert
    logic [7:0]  r_ampl;
    logic [7:0]  r_duty;
    logic [7:0]  r_wrap_cnt;
    logic [7:0]  r_lfsr;
    logic        r_sync_q;
    logic [7:0]  r_raw;
    logic [7:0]  r_out;

    // Combinational helpers
    logic        w_enable;
    logic        w_sync_edge;
    logic [16:0] w_sum;
    logic        w_wrap;
    logic [7:0]  w_p;
    logic [7:0]  w_raw;
    logic [8:0]  w_ampl_p1;
    logic [16:0] w_product;
    logic [7:0]  w_scaled;
    logic [7:0]  w_lfsr_next;
    logic        w_unused;

    assign w_enable    = r_ctrl[0];
    assign w_sync_edge = r_ctrl[3] & ui_in[0] & ~r_sync_q;
    assign w_sum       = {1'b0, r_phase} + {1'b0, r_inc};
    // A sync reset takes priority over the increment, so its carry is discarded
    assign w_wrap      = w_enable & w_sum[16] & ~w_sync_edge;
    assign w_p         = r_phase[15:8];
    // Fibonacci LFSR for x^8+x^6+x^5+x^4+1, shifting left
    assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    // Max product is 255*256, so bit 16 never sets and [15:8] is the full result
    assign w_ampl_p1   = {1'b0, r_ampl} + 9'd1;
    assign w_product   = {9'd0, r_raw} * {8'd0, w_ampl_p1};
    assign w_scaled    = w_product[15:8];
    assign w_unused    = &{1'b0, ui_in[7:1], w_product[16]};

    assign uo_out = r_out;

    // Waveform shaping from the top byte of the phase
    always_comb begin
        w_raw = 8'h00;
        case (r_ctrl[2:1])
            c_WAVE_SQUARE:   w_raw = (w_p < r_duty) ? 8'hFF : 8'h00;
            c_WAVE_SAW:      w_raw = w_p;
            c_WAVE_TRIANGLE: w_raw = w_p[7] ? ~{w_p[6:0], 1'b0} : {w_p[6:0], 1'b0};
            c_WAVE_NOISE:    w_raw = r_lfsr;
            default:         w_raw = 8'h00;
        endcase
    end

    // Bus-writable configuration registers; INC is committed atomically from the shadow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl   <= 5'h00;
            r_shadow <= 8'h00;
            r_inc    <= 16'h0000;
            r_ampl   <= 8'hFF;
            r_duty   <= 8'h80;
        end else if (data_write) begin
            case (address)
                c_ADDR_CTRL:   r_ctrl   <= data_in[4:0];
                c_ADDR_INC_LO: r_shadow <= data_in;
                c_ADDR_INC_HI: r_inc    <= {data_in, r_shadow};
                c_ADDR_AMPL:   r_ampl   <= data_in;
                c_ADDR_DUTY:   r_duty   <= data_in;
                default:       ;
            endcase
        end
    end

    // Phase accumulator with external sync reset on a rising ui_in[0]
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase  <= 16'h0000;
            r_sync_q <= 1'b0;
        end else begin
            r_sync_q <= ui_in[0];
            if (w_sync_edge) begin
                r_phase <= 16'h0000;
            end else if (w_enable) begin
                r_phase <= w_sum[15:0];
            end
        end
    end

    // Wrap counter and noise LFSR, both stepped by accumulator carry; a bus write clears the counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrap_cnt <= 8'h00;
            r_lfsr     <= 8'h01;
        end else begin
            if (w_wrap) begin
                r_lfsr <= w_lfsr_next;
            end
            if (data_write && (address == c_ADDR_WRAP_CNT)) begin
                r_wrap_cnt <= 8'h00;
            end else if (w_wrap) begin
                r_wrap_cnt <= r_wrap_cnt + 8'd1;
            end
        end
    end

    // Two-stage output pipeline: raw sample, then amplitude scaling and optional inversion
    always_ff @(posedge clk) begin
        if (rst) begin
            r_raw <= 8'h00;
            r_out <= 8'h00;
        end else begin
            r_raw <= w_raw;
            r_out <= r_ctrl[4] ? ~w_scaled : w_scaled;
        end
    end

    // Read mux for the register bridge
    always_comb begin
        data_out = 8'h00;
        case (address)
            c_ADDR_CTRL:     data_out = {3'b000, r_ctrl};
            c_ADDR_INC_LO:   data_out = r_shadow;
            c_ADDR_INC_HI:   data_out = r_inc[15:8];
            c_ADDR_AMPL:     data_out = r_ampl;
            c_ADDR_DUTY:     data_out = r_duty;
            c_ADDR_PHASE_HI: data_out = r_phase[15:8];
            c_ADDR_WRAP_CNT: data_out = r_wrap_cnt;
            default:         data_out = 8'h00;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_tqvp_wave_dds.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tqvp_wave_dds
//  Description : Scoreboard testbench for tqvp_wave_dds with a behavioural
//                reference model driven by directed and random stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tqvp_wave_dds;

    logic       clk        = 1'b0;
    logic       rst        = 1'b0;
    logic [7:0] ui_in      = 8'h00;
    logic [7:0] uo_out;
    logic [3:0] address    = 4'h0;
    logic       data_write = 1'b0;
    logic [7:0] data_in    = 8'h00;
    logic [7:0] data_out;

    always #5 clk = ~clk;

    tqvp_wave_dds dut (
        .clk        (clk),
        .rst        (rst),
        .ui_in      (ui_in),
        .uo_out     (uo_out),
        .address    (address),
        .data_write (data_write),
        .data_in    (data_in),
        .data_out   (data_out)
    );

    typedef struct packed {
        logic [7:0] uo;
        logic [7:0] dout;
        logic [3:0] addr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;

    // Behavioural model state (plain integers)
    int m_phase, m_inc, m_shadow, m_ctrl, m_ampl, m_duty, m_wrap, m_lfsr;
    int m_raw, m_out, m_sync_q;
    bit m_valid = 1'b0;
    logic [7:0] ui_cur = 8'h00;

    function automatic int raw_of(int wave, int p, int duty, int lfsr);
        case (wave)
            0:       return (p < duty) ? 255 : 0;
            1:       return p;
            2:       return (p < 128) ? 2 * p : 255 - 2 * (p - 128);
            default: return lfsr;
        endcase
    endfunction

    function automatic int scale_of(int raw, int ampl, int inv);
        int s;
        s = (raw * (ampl + 1)) / 256;
        return (inv != 0) ? 255 - s : s;
    endfunction

    function automatic int lfsr_step(int l);
        logic [7:0] taps;
        taps = 8'(l) & 8'hB8;
        return ((l * 2) % 256) + ($countones(taps) % 2);
    endfunction

    function automatic int read_of(int a);
        case (a)
            0:       return m_ctrl;
            1:       return m_shadow;
            2:       return m_inc / 256;
            3:       return m_ampl;
            4:       return m_duty;
            5:       return m_phase / 256;
            6:       return m_wrap;
            default: return 0;
        endcase
    endfunction

    task automatic model_update(input bit r, input bit we, input int a, input int d, input int u0);
        int en, wave, sen, inv, sync, sum, wrap, nraw, nout;
        if (r) begin
            m_phase = 0; m_inc = 0; m_shadow = 0; m_ctrl = 0;
            m_ampl = 255; m_duty = 128; m_wrap = 0; m_lfsr = 1;
            m_raw = 0; m_out = 0; m_sync_q = 0;
            m_valid = 1'b1;
            return;
        end
        en   = m_ctrl % 2;
        wave = (m_ctrl / 2) % 4;
        sen  = (m_ctrl / 8) % 2;
        inv  = (m_ctrl / 16) % 2;
        sync = (sen == 1 && u0 == 1 && m_sync_q == 0) ? 1 : 0;
        sum  = m_phase + m_inc;
        wrap = (en == 1 && sync == 0 && sum > 65535) ? 1 : 0;
        nraw = raw_of(wave, m_phase / 256, m_duty, m_lfsr);
        nout = scale_of(m_raw, m_ampl, inv);
        if (sync == 1)    m_phase = 0;
        else if (en == 1) m_phase = sum % 65536;
        if (wrap == 1) begin
            m_lfsr = lfsr_step(m_lfsr);
            m_wrap = (m_wrap + 1) % 256;
        end
        if (we) begin
            case (a)
                0: m_ctrl   = d % 32;
                1: m_shadow = d;
                2: m_inc    = d * 256 + m_shadow;
                3: m_ampl   = d;
                4: m_duty   = d;
                6: m_wrap   = 0;
                default: ;
            endcase
        end
        m_sync_q = u0;
        m_raw    = nraw;
        m_out    = nout;
    endtask

    // One clock of stimulus: drive inputs, record what the DUT must show now, advance the model
    task automatic step(input bit r, input bit we, input logic [3:0] a, input logic [7:0] d, input logic [7:0] u);
        exp_t t;
        @(posedge clk);
        #1;
        rst = r; data_write = we; address = a; data_in = d; ui_in = u;
        if (m_valid) begin
            t.uo   = 8'(m_out);
            t.dout = 8'(read_of(int'(a)));
            t.addr = a;
            exp_q.push_back(t);
        end
        model_update(r, we, int'(a), int'(d), int'(u[0]));
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        step(1'b0, 1'b1, a, d, ui_cur);
    endtask

    task automatic idle(input int n, input logic [3:0] a);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, a, 8'h00, ui_cur);
    endtask

    task automatic idle_alt(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, (i % 2 == 0) ? 4'h5 : 4'h6, 8'h00, ui_cur);
    endtask

    // Monitor: every cycle the DUT presents a sample and a read value; compare against the queue head
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            vectors++;
            if (uo_out !== mon_e.uo) begin
                miscompares++;
                $display("FAIL uo_out: got %02h expected %02h at %0t", uo_out, mon_e.uo, $time);
            end
            vectors++;
            if (data_out !== mon_e.dout) begin
                miscompares++;
                $display("FAIL data_out[addr %0h]: got %02h expected %02h at %0t",
                         mon_e.addr, data_out, mon_e.dout, $time);
            end
        end
    end

    initial begin
        // Reset
        step(1'b1, 1'b0, 4'h0, 8'h00, 8'h00);
        step(1'b1, 1'b1, 4'h3, 8'h12, 8'h00);
        for (int a = 0; a < 8; a++) step(1'b0, 1'b0, 4'(a), 8'h00, 8'h00);

        // Sawtooth, inc 0x0100, full amplitude, through one full wrap
        wr(4'h1, 8'h00); wr(4'h2, 8'h01); wr(4'h3, 8'hFF); wr(4'h0, 8'h03);
        idle_alt(262);

        // Square, inc 0x1000, duty 0x40, then inverted
        wr(4'h1, 8'h00); wr(4'h2, 8'h10); wr(4'h4, 8'h40); wr(4'h0, 8'h01);
        idle(34, 4'h5);
        wr(4'h0, 8'h11);
        idle(34, 4'h5);

        // Triangle sweep
        wr(4'h2, 8'h04); wr(4'h0, 8'h05);
        idle(70, 4'h5);

        // Scaling: sync phase to 0, run saw up to 0xFF, then hold
        wr(4'h1, 8'h00); wr(4'h2, 8'h01); wr(4'h0, 8'h0B);
        ui_cur = 8'h01; idle(1, 4'h5);
        idle(254, 4'h5);
        wr(4'h0, 8'h02);
        idle(4, 4'h5);
        wr(4'h3, 8'h7F); idle(4, 4'h5);
        wr(4'h3, 8'h00); idle(4, 4'h5);
        wr(4'h3, 8'hFF);

        // Sync with running phase; held-high input must not resync
        ui_cur = 8'h00;
        wr(4'h0, 8'h0B);
        idle(6, 4'h5);
        ui_cur = 8'hFF; idle(10, 4'h5);
        ui_cur = 8'h00; idle(3, 4'h5);
        ui_cur = 8'h01; idle(3, 4'h5);
        ui_cur = 8'h00;

        // Shadow-only write leaves inc alone
        wr(4'h1, 8'h55);
        idle(2, 4'h2); idle(2, 4'h1); idle(4, 4'h5);

        // Wrap on nearly every cycle, with WRAP_CNT clears colliding
        wr(4'h1, 8'hFF); wr(4'h2, 8'hFF); wr(4'h0, 8'h01);
        idle(3, 4'h6);
        wr(4'h6, 8'hAA); idle(1, 4'h6);
        wr(4'h6, 8'h00); wr(4'h6, 8'h00); idle(3, 4'h6);

        // Noise, then reset mid-run
        wr(4'h1, 8'h00); wr(4'h2, 8'h40); wr(4'h0, 8'h17);
        idle(20, 4'h6);
        step(1'b1, 1'b1, 4'h0, 8'h1F, 8'h01);
        for (int a = 0; a < 16; a++) step(1'b0, 1'b0, 4'(a), 8'h00, 8'h00);
        ui_cur = 8'h00;

        // Randomised traffic
        for (int i = 0; i < 2000; i++) begin
            bit         r, we;
            logic [3:0] a;
            logic [7:0] d;
            r  = ($urandom_range(0, 499) == 0);
            we = ($urandom_range(0, 3) == 0);
            a  = we ? 4'($urandom_range(0, 8)) : 4'($urandom_range(0, 15));
            d  = 8'($urandom);
            if (we && a == 4'h2) d = 8'($urandom_range(0, 15)) << $urandom_range(0, 4);
            if ($urandom_range(0, 7) == 0) ui_cur[0] = ~ui_cur[0];
            ui_cur[7:1] = 7'($urandom);
            step(r, we, a, d, ui_cur);
        end

        @(posedge clk); #1;
        data_write = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
